// File: rtl/rv32i_pkg.sv
// Shared RV32I decode constants: opcodes, funct3 encodings and the funct7 alternate marker.
package rv32i_pkg;

    typedef enum logic [6:0] {
        OP     = 7'b0110011,
        OP_IMM = 7'b0010011,
        LOAD   = 7'b0000011,
        STORE  = 7'b0100011,
        BRANCH = 7'b1100011,
        LUI    = 7'b0110111
    } opcode_e;

    typedef enum logic [2:0] {
        F3_ADD  = 3'b000,
        F3_SLL  = 3'b001,
        F3_SLT  = 3'b010,
        F3_SLTU = 3'b011,
        F3_XOR  = 3'b100,
        F3_SR   = 3'b101,
        F3_OR   = 3'b110,
        F3_AND  = 3'b111
    } alu_f3_e;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } br_f3_e;

    localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

endpackage

// File: rtl/alu_if.sv
// Execute-stage bundle between decoder/register file and the ALU.
interface alu_if;

    logic        ALU_source;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [31:0] immediate;
    logic [31:0] result;
    logic [31:0] read_address;
    logic [31:0] write_address;
    logic        branch;

    modport master (
        output ALU_source, opcode, funct3, funct7, reg1, reg2, immediate,
        input  result, read_address, write_address, branch
    );

    modport slave (
        input  ALU_source, opcode, funct3, funct7, reg1, reg2, immediate,
        output result, read_address, write_address, branch
    );

endinterface

// File: rtl/alu_branch_cmp.sv
// Conditional-branch comparator on rs1/rs2; unused funct3 codes never take the branch.
module branch_cmp
    import rv32i_pkg::*;
(
    input  logic [31:0] reg1,
    input  logic [31:0] reg2,
    input  logic [2:0]  funct3,
    output logic        branch
);

    always_comb begin
        branch = 1'b0;
        case (funct3)
            F3_BEQ:  branch = (reg1 == reg2);
            F3_BNE:  branch = (reg1 != reg2);
            F3_BLT:  branch = ($signed(reg1) <  $signed(reg2));
            F3_BGE:  branch = ($signed(reg1) >= $signed(reg2));
            F3_BLTU: branch = (reg1 <  reg2);
            F3_BGEU: branch = (reg1 >= reg2);
            default: branch = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu.sv
// Combinational RV32I execute-stage ALU: integer result, load/store addresses, branch decision.
module alu
    import rv32i_pkg::*;
(
    input  logic clk,
    input  logic nrst,
    alu_if.slave bus
);

    logic [31:0] op_b;
    logic [4:0]  shamt;
    logic        alt;
    logic        cmp_taken;
    logic [31:0] result;
    logic [31:0] read_address;
    logic [31:0] write_address;

    // clk/nrst exist only for pipeline integration; the block holds no state.
    logic unused_clk_nrst;
    assign unused_clk_nrst = clk ^ nrst;

    assign op_b  = bus.ALU_source ? bus.immediate : bus.reg2;
    assign shamt = op_b[4:0];
    assign alt   = (bus.funct7 == FUNCT7_ALT);

    branch_cmp u_branch_cmp (
        .reg1   (bus.reg1),
        .reg2   (bus.reg2),
        .funct3 (bus.funct3),
        .branch (cmp_taken)
    );

    always_comb begin
        result        = '0;
        read_address  = '0;
        write_address = '0;
        case (bus.opcode)
            OP, OP_IMM: begin
                case (bus.funct3)
                    F3_ADD:  result = alt ? (bus.reg1 - op_b) : (bus.reg1 + op_b);
                    F3_SLL:  result = bus.reg1 << shamt;
                    F3_SLT:  result = {31'b0, ($signed(bus.reg1) < $signed(op_b))};
                    F3_SLTU: result = {31'b0, (bus.reg1 < op_b)};
                    F3_XOR:  result = bus.reg1 ^ op_b;
                    F3_SR:   result = alt ? 32'($signed(bus.reg1) >>> shamt) : (bus.reg1 >> shamt);
                    F3_OR:   result = bus.reg1 | op_b;
                    F3_AND:  result = bus.reg1 & op_b;
                    default: result = '0;
                endcase
            end
            LOAD: begin
                read_address = bus.reg1 + bus.immediate;
                result       = read_address;
            end
            STORE: begin
                write_address = bus.reg1 + bus.immediate;
                result        = write_address;
            end
            LUI:     result = bus.immediate;
            default: result = '0;
        endcase
    end

    assign bus.result        = result;
    assign bus.read_address  = read_address;
    assign bus.write_address = write_address;
    assign bus.branch        = (bus.opcode == BRANCH) ? cmp_taken : 1'b0;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the combinational RV32I ALU.
module tb_alu;
    import rv32i_pkg::*;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    int unsigned total = 0;
    int unsigned bad = 0;

    alu_if bus ();

    alu dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic src, input logic [6:0] opc, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] imm);
        @(negedge clk);
        bus.ALU_source = src;
        bus.opcode     = opc;
        bus.funct3     = f3;
        bus.funct7     = f7;
        bus.reg1       = r1;
        bus.reg2       = r2;
        bus.immediate  = imm;
        #1;
    endtask

    task automatic check_br(input string tag, input logic [31:0] exp);
        check(tag, {31'b0, bus.branch}, exp);
    endtask

    initial begin
        // Outputs must already follow inputs while nrst is low.
        drive(1'b0, OP, 3'b000, 7'h00, 32'd1, 32'd0, 32'hDEAD_BEEF);
        check("add_in_reset", bus.result, 32'd1);
        check("add_rd_zero", bus.read_address, 32'd0);
        check("add_wr_zero", bus.write_address, 32'd0);
        check_br("add_no_branch", 32'd0);
        nrst = 1'b1;

        drive(1'b1, OP_IMM, 3'b000, 7'h00, 32'd0, 32'hFFFF_FFFF, 32'd1);
        check("addi", bus.result, 32'd1);
        drive(1'b0, OP, 3'b000, 7'h20, 32'd1, 32'd1, 32'd7);
        check("sub", bus.result, 32'd0);
        drive(1'b1, OP_IMM, 3'b000, 7'h20, 32'd1, 32'd9, 32'd1);
        check("subi", bus.result, 32'd0);
        drive(1'b0, OP, 3'b000, 7'h20, 32'd0, 32'd1, 32'd0);
        check("sub_wrap", bus.result, 32'hFFFF_FFFF);
        drive(1'b0, OP, 3'b000, 7'h00, 32'hFFFF_FFFF, 32'd2, 32'd0);
        check("add_wrap", bus.result, 32'd1);

        for (int unsigned s = 0; s < 2; s++) begin
            drive(s[0], OP, 3'b100, 7'h00, 32'd1, 32'd0, 32'd0);
            check($sformatf("xor_src%0d", s), bus.result, 32'd1);
            drive(s[0], OP, 3'b110, 7'h00, 32'd1, 32'd0, 32'd0);
            check($sformatf("or_src%0d", s), bus.result, 32'd1);
            drive(s[0], OP, 3'b111, 7'h00, 32'd1, 32'd1, 32'd1);
            check($sformatf("and_src%0d", s), bus.result, 32'd1);
        end
        drive(1'b0, OP, 3'b111, 7'h00, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0);
        check("and_pat", bus.result, 32'h00F0_00F0);
        drive(1'b1, OP_IMM, 3'b100, 7'h00, 32'hF0F0_F0F0, 32'd0, 32'h0FF0_0FF0);
        check("xori_pat", bus.result, 32'hFF00_FF00);

        drive(1'b0, OP, 3'b001, 7'h00, 32'hFFFF_FFFF, 32'd31, 32'd0);
        check("sll31", bus.result, 32'h8000_0000);
        drive(1'b0, OP, 3'b001, 7'h00, 32'hFFFF_FFFF, 32'd16, 32'd0);
        check("sll16", bus.result, 32'hFFFF_0000);
        drive(1'b0, OP, 3'b001, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0);
        check("sll1", bus.result, 32'hFFFF_FFFE);
        drive(1'b0, OP, 3'b001, 7'h00, 32'hFFFF_FFFF, 32'hFFFF_FFE1, 32'd0);
        check("sll_upper_ignored", bus.result, 32'hFFFF_FFFE);
        drive(1'b0, OP, 3'b101, 7'h00, 32'hFFFF_FFFF, 32'd31, 32'd0);
        check("srl31", bus.result, 32'h0000_0001);
        drive(1'b0, OP, 3'b101, 7'h00, 32'hFFFF_FFFF, 32'd16, 32'd0);
        check("srl16", bus.result, 32'h0000_FFFF);
        drive(1'b0, OP, 3'b101, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0);
        check("srl1", bus.result, 32'h7FFF_FFFF);
        drive(1'b0, OP, 3'b101, 7'h20, 32'hFFFF_FFFF, 32'd4, 32'd0);
        check("sra4", bus.result, 32'hFFFF_FFFF);
        drive(1'b0, OP, 3'b101, 7'h20, 32'h8000_0000, 32'd4, 32'd0);
        check("sra4_msb", bus.result, 32'hF800_0000);
        drive(1'b1, OP_IMM, 3'b001, 7'h00, 32'hFFFF_FFFF, 32'd0, 32'd31);
        check("slli31", bus.result, 32'h8000_0000);

        drive(1'b0, OP, 3'b010, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0);
        check("slt", bus.result, 32'd1);
        drive(1'b0, OP, 3'b011, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0);
        check("sltu", bus.result, 32'd0);
        drive(1'b1, OP_IMM, 3'b011, 7'h00, 32'd1, 32'd0, 32'hFFFF_FFFF);
        check("sltiu", bus.result, 32'd1);

        drive(1'b0, BRANCH, 3'b000, 7'h00, 32'd5, 32'd5, 32'd0);
        check_br("beq", 32'd1);
        check("br_result", bus.result, 32'd0);
        drive(1'b1, BRANCH, 3'b001, 7'h00, 32'd5, 32'd5, 32'd9);
        check_br("bne_src_ignored", 32'd0);
        drive(1'b0, BRANCH, 3'b100, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0);
        check_br("blt", 32'd1);
        drive(1'b0, BRANCH, 3'b101, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0);
        check_br("bge", 32'd0);
        drive(1'b0, BRANCH, 3'b110, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0);
        check_br("bltu", 32'd0);
        drive(1'b0, BRANCH, 3'b111, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0);
        check_br("bgeu", 32'd1);
        drive(1'b0, BRANCH, 3'b010, 7'h00, 32'd5, 32'd5, 32'd0);
        check_br("b_f3_010", 32'd0);
        drive(1'b0, OP, 3'b000, 7'h00, 32'd5, 32'd5, 32'd0);
        check_br("op_no_branch", 32'd0);

        drive(1'b0, LOAD, 3'b010, 7'h00, 32'h100, 32'd0, 32'd4);
        check("load_rd", bus.read_address, 32'h104);
        check("load_wr", bus.write_address, 32'd0);
        check("load_res", bus.result, 32'h104);
        drive(1'b0, STORE, 3'b010, 7'h00, 32'h100, 32'h55, 32'd4);
        check("store_wr", bus.write_address, 32'h104);
        check("store_rd", bus.read_address, 32'd0);
        drive(1'b0, LUI, 3'b000, 7'h00, 32'd7, 32'd7, 32'h1234_5000);
        check("lui", bus.result, 32'h1234_5000);
        drive(1'b1, 7'b1111111, 3'b000, 7'h00, 32'd7, 32'd7, 32'd7);
        check("unknown_op", bus.result, 32'd0);

        // Toggle reset across clock edges with a fixed ADD applied.
        drive(1'b0, OP, 3'b000, 7'h00, 32'd40, 32'd2, 32'd0);
        nrst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_low_hold", bus.result, 32'd42);
        nrst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_high_hold", bus.result, 32'd42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
